ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_pkg.sv | 19 +
 rtl/ram_stream_reader_if.sv | 29 ++
 rtl/ram_stream_reader_fifo.sv | 55 +++++
 rtl/ram_stream_reader.sv | 138 +++++++++++++
 tb/tb_ram_stream_reader.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Shared defaults and types for the RAM burst reader and its output buffer.
package ram_pkg;

    localparam int ADDR_SIZE_DEF  = 16;
    localparam int DATA_SIZE_DEF  = 32;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } reader_state_e;

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// RAM read-only port plus ready/valid output stream of the burst reader.
interface ram_stream_reader_if #(
    parameter int ADDR_SIZE = ram_pkg::ADDR_SIZE_DEF,
    parameter int DATA_SIZE = ram_pkg::DATA_SIZE_DEF
) ();

    logic [ADDR_SIZE-1:0] addr_B;
    logic [DATA_SIZE-1:0] data_out_B;
    logic [DATA_SIZE-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output addr_B,
        input  data_out_B,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  addr_B,
        output data_out_B,
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/ram_stream_reader_fifo.sv
// Small synchronous FIFO; head word is presented combinationally, zero when empty.
module sync_fifo
    import ram_pkg::*;
#(
    parameter int WIDTH = DATA_SIZE_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst reader: walks length words from base_addr through a 1-cycle-latency RAM
// port and streams them out in address order via a small buffer.
module ram_stream_reader
    import ram_pkg::*;
#(
    parameter int ADDR_SIZE  = ADDR_SIZE_DEF,
    parameter int DATA_SIZE  = DATA_SIZE_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [ADDR_SIZE:0]   length,
    output logic                 busy,
    output logic                 done,
    ram_stream_reader_if.master  bus
);

    localparam int CW = count_width(FIFO_DEPTH);

    reader_state_e        state;
    reader_state_e        state_next;
    logic [ADDR_SIZE-1:0] base_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [ADDR_SIZE-1:0] issue_addr;
    logic [ADDR_SIZE:0]   length_q;
    logic [ADDR_SIZE:0]   issued;
    logic [ADDR_SIZE:0]   xfer;
    logic [ADDR_SIZE:0]   xfer_next;
    logic                 rd_issue;
    logic                 rd_pending;
    logic                 done_q;
    logic                 issue_next;
    logic                 done_next;
    logic                 accept;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop;
    logic                 room;
    logic [CW-1:0]        fifo_count;
    logic [CW:0]          in_use;

    // rd_issue: addr_B carries a live read this cycle; rd_pending: its data is on data_out_B.
    assign pop       = !fifo_empty && bus.out_ready;
    assign xfer_next = xfer + {{ADDR_SIZE{1'b0}}, pop};
    assign in_use    = {1'b0, fifo_count} + (CW+1)'(rd_pending) + (CW+1)'(rd_issue)
                       - (CW+1)'(pop);
    assign room      = (in_use < (CW+1)'(FIFO_DEPTH));

    assign bus.addr_B    = addr_q;
    assign bus.out_valid = !fifo_empty;
    assign busy          = (state != IDLE) && !done_q;
    assign done          = done_q;

    always_ff @(posedge clk) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    // Reads are scheduled one edge ahead so addr_B is registered when the RAM samples it.
    always_comb begin
        state_next = state;
        issue_next = 1'b0;
        done_next  = 1'b0;
        accept     = 1'b0;
        issue_addr = base_q + issued[ADDR_SIZE-1:0];
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (length == '0) begin
                        state_next = DRAIN;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RUN;
                        issue_next = 1'b1;
                        issue_addr = base_addr;
                    end
                end
            end
            RUN: begin
                if (issued == length_q) state_next = DRAIN;
                else if (room)          issue_next = 1'b1;
            end
            DRAIN: begin
                if (xfer_next == length_q) begin
                    state_next = IDLE;
                    done_next  = (length_q != '0);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            base_q     <= '0;
            length_q   <= '0;
            issued     <= '0;
            xfer       <= '0;
            addr_q     <= '0;
            rd_issue   <= 1'b0;
            rd_pending <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            rd_issue   <= issue_next;
            rd_pending <= rd_issue;
            done_q     <= done_next;
            if (issue_next) addr_q <= issue_addr;
            if (accept) begin
                base_q   <= base_addr;
                length_q <= length;
                xfer     <= '0;
                issued   <= issue_next ? (ADDR_SIZE+1)'(1) : '0;
            end else begin
                xfer <= xfer_next;
                if (issue_next) issued <= issued + (ADDR_SIZE+1)'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (DATA_SIZE),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (RST),
        .push      (rd_pending && !fifo_full),
        .push_data (bus.data_out_B),
        .pop       (pop),
        .pop_data  (bus.out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: queue-based stream model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ram_stream_reader;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          RST;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;

    ram_stream_reader_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

    ram_stream_reader #(
        .ADDR_SIZE  (AW),
        .DATA_SIZE  (DW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .RST       (RST),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] ram [65536];

    always @(posedge clk) bus.data_out_B <= ram[bus.addr_B];

    int errors = 0;
    int checks = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference: a burst is a list of RAM words queued at acceptance; done follows the last transfer.
    logic [DW-1:0] exp_q [$];
    int  phase       = 0;
    int  remaining   = 0;
    bit  exp_done    = 1'b0;
    bit  exp_busy    = 1'b0;
    bit  after_reset = 1'b0;
    bit  model_on    = 1'b0;

    always @(negedge clk) begin
        bit            idle_now;
        bit            nd;
        logic [AW-1:0] a;
        if (model_on) begin
            checkOutput("done", 64'(done), 64'(exp_done));
            checkOutput("busy", 64'(busy), 64'(exp_busy));
            if (bus.out_valid === 1'b1) begin
                if (exp_q.size() == 0)
                    checkOutput("out_valid_no_word", 64'(bus.out_valid), 64'(0));
                else
                    checkOutput("out_data", 64'(bus.out_data), 64'(exp_q[0]));
            end
            if (after_reset) begin
                checkOutput("rst_addr_B", 64'(bus.addr_B), 64'(0));
                checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
                checkOutput("rst_out_data", 64'(bus.out_data), 64'(0));
            end
        end
        if (RST === 1'b1) begin
            exp_q.delete();
            phase       = 0;
            remaining   = 0;
            exp_done    = 1'b0;
            exp_busy    = 1'b0;
            after_reset = 1'b1;
            model_on    = 1'b1;
        end else if (model_on) begin
            after_reset = 1'b0;
            nd          = 1'b0;
            idle_now    = (phase == 0);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                remaining--;
                if (remaining == 0 && phase == 1) begin
                    phase = 0;
                    nd    = 1'b1;
                end
            end
            if (phase == 2) phase = 0;
            if (start === 1'b1 && idle_now) begin
                if (length == '0) begin
                    phase = 2;
                    nd    = 1'b1;
                end else begin
                    phase     = 1;
                    remaining = int'(length);
                    for (int i = 0; i < int'(length); i++) begin
                        a = base_addr + 16'(i);
                        exp_q.push_back(ram[a]);
                    end
                end
            end
            exp_done = nd;
            exp_busy = (phase == 1);
        end
    end

    task automatic applyStimulus(input logic [AW-1:0] base, input logic [AW:0] len);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        length    = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 64'(done), 64'(1));
    endtask

    initial begin
        logic [AW-1:0] ea;
        RST           = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        length        = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 65536; i++) ram[i] = $urandom;
        ram[16'h0010] = 32'hA0;
        ram[16'h0011] = 32'hA1;
        ram[16'h0012] = 32'hA2;
        ram[16'h0013] = 32'hA3;

        repeat (3) @(posedge clk);
        #1 RST = 1'b0;
        @(negedge clk);
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("reset_addr", 64'(bus.addr_B), 64'(0));

        $display("[TB] burst base 0x10 len 4");
        applyStimulus(16'h0010, 17'd4);
        @(negedge clk);
        checkOutput("first_addr", 64'(bus.addr_B), 64'h10);
        checkOutput("first_busy", 64'(busy), 64'(1));
        @(negedge clk);
        checkOutput("latency_valid_low", 64'(bus.out_valid), 64'(0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("burst_valid", 64'(bus.out_valid), 64'(1));
            checkOutput("burst_data", 64'(bus.out_data), 64'(32'hA0 + 32'(k)));
        end
        @(negedge clk);
        checkOutput("burst_done", 64'(done), 64'(1));
        checkOutput("burst_busy_low", 64'(busy), 64'(0));
        checkOutput("burst_valid_low", 64'(bus.out_valid), 64'(0));

        $display("[TB] address wrap base 0xFFFE len 4");
        applyStimulus(16'hFFFE, 17'd4);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ea = 16'hFFFE + 16'(k);
            checkOutput("wrap_addr", 64'(bus.addr_B), 64'(ea));
            if (k == 2) checkOutput("wrap_first_word", 64'(bus.out_data), 64'(ram[16'hFFFE]));
        end
        waitDone("wrap_done", 20);

        $display("[TB] backpressure len 8");
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        applyStimulus(16'h0100, 17'd8);
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 3 || j == 10) begin
                checkOutput("stall_valid", 64'(bus.out_valid), 64'(1));
                checkOutput("stall_data", 64'(bus.out_data), 64'(ram[16'h0100]));
            end
        end
        checkOutput("stall_reads_issued", 64'(bus.addr_B), 64'h103);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        waitDone("stall_done", 40);

        $display("[TB] zero length");
        applyStimulus(16'h0500, 17'd0);
        @(negedge clk);
        checkOutput("zero_done", 64'(done), 64'(1));
        checkOutput("zero_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("zero_no_read", 64'(bus.addr_B), 64'h107);
        @(negedge clk);
        checkOutput("zero_done_pulse", 64'(done), 64'(0));

        $display("[TB] start while busy");
        applyStimulus(16'h0200, 17'd6);
        start     = 1'b1;
        base_addr = 16'h0040;
        length    = 17'd3;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone("busy_start_done", 40);
        checkOutput("busy_start_addr", 64'(bus.addr_B), 64'h205);
        @(negedge clk);
        checkOutput("busy_start_ignored", 64'(busy), 64'(0));

        $display("[TB] reset mid-burst");
        applyStimulus(16'h0300, 17'd6);
        repeat (4) @(posedge clk);
        #1 RST = 1'b1;
        @(posedge clk);
        #1 RST = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", 64'(busy), 64'(0));
        checkOutput("abort_done", 64'(done), 64'(0));
        checkOutput("abort_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("abort_addr", 64'(bus.addr_B), 64'(0));
        checkOutput("abort_data", 64'(bus.out_data), 64'(0));
        applyStimulus(16'h0310, 17'd2);
        repeat (2) @(negedge clk);
        @(negedge clk);
        checkOutput("restart_word0", 64'(bus.out_data), 64'(ram[16'h0310]));
        @(negedge clk);
        checkOutput("restart_word1", 64'(bus.out_data), 64'(ram[16'h0311]));
        @(negedge clk);
        checkOutput("restart_done", 64'(done), 64'(1));
        @(negedge clk);
        checkOutput("restart_no_extra", 64'(bus.out_valid), 64'(0));

        $display("[TB] randomized traffic");
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            start         = ($urandom_range(0, 5) == 0);
            base_addr     = 16'($urandom);
            length        = 17'($urandom_range(0, 12));
            RST           = ($urandom_range(0, 249) == 0);
        end
        @(posedge clk);
        #1;
        start         = 1'b0;
        RST           = 1'b0;
        bus.out_ready = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("final_busy", 64'(busy), 64'(0));
        checkOutput("final_valid", 64'(bus.out_valid), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
